dac_arbiter: RTL

DAC_ARBITER -- requirements
Module: dac_arbiter

---
 rtl/dac_pkg.sv | 20 ++
 rtl/dac_tick_gen.sv | 37 +++
 rtl/dac_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// Shared types and frame layout for the serial DAC arbiter.
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int FRAME_BITS = 16;
    localparam int DUMMY_BITS = 4;
    localparam int DATA_BITS  = 10;
    localparam int PAD_BITS   = 2;

    // Frame as shifted out MSB first: zero dummies, DAC code, zero sub-LSB pad.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] data);
        return {{DUMMY_BITS{1'b0}}, data, {PAD_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// Half-period tick generator: one-cycle pulse every CLK_DIV enabled cycles.
module dac_tick_gen #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: restart on frame start, wrap at the end of each half-period.
    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/dac_arbiter.sv
// Two-requester round-robin arbiter feeding a 16-bit serial DAC frame.
module dac_arbiter
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 10,
    parameter int unsigned CS_GAP  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [DATA_BITS-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_BITS-1:0] req1_data,
    output logic                 req1_ready,
    output logic                 sclk,
    output logic                 cs,
    output logic                 din,
    output logic                 busy,
    output logic                 grant_id
);

    localparam logic [4:0]  LAST_BIT = 5'(FRAME_BITS - 1);
    localparam logic [11:0] GAP_LAST = 12'(2 * CS_GAP - 1);

    state_e                  state_q, state_d;
    logic                    sclk_q, sclk_d;
    logic                    cs_q, cs_d;
    logic                    din_q, din_d;
    logic                    grant_id_q, grant_id_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [11:0]             gap_cnt_q, gap_cnt_d;

    logic                    grant;
    logic                    accept;
    logic                    tick;
    logic [DATA_BITS-1:0]    sel_data;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ~grant_id_q;
        else if (req1_valid)          grant = 1'b1;
    end

    assign req0_ready = rst_n && (state_q == ST_IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state_q == ST_IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;
    assign sel_data   = grant ? req1_data : req0_data;

    dac_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    ((state_q == ST_SHIFT) || (state_q == ST_GAP)),
        .clr   (accept),
        .tick  (tick)
    );

    // Frame sequencing: capture on accept, toggle sclk on ticks, shift on falling sclk.
    always_comb begin
        state_d    = state_q;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        din_d      = din_q;
        grant_id_d = grant_id_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SHIFT;
                    cs_d       = 1'b0;
                    sclk_d     = 1'b0;
                    shreg_d    = build_frame(sel_data);
                    din_d      = shreg_d[FRAME_BITS-1];
                    grant_id_d = grant;
                    bit_cnt_d  = '0;
                    gap_cnt_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d   = ST_GAP;
                            cs_d      = 1'b1;
                            din_d     = 1'b0;
                            bit_cnt_d = '0;
                            gap_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            shreg_d   = {shreg_q[FRAME_BITS-2:0], shreg_q[FRAME_BITS-1]};
                            din_d     = shreg_q[FRAME_BITS-2];
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d   = ST_IDLE;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 12'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; a mid-frame reset drops the partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            din_q      <= 1'b0;
            grant_id_q <= 1'b1;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            din_q      <= din_d;
            grant_id_q <= grant_id_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign sclk     = sclk_q;
    assign cs       = cs_q;
    assign din      = din_q;
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_id_q;

endmodule
